// File: rtl/gb_cart_pkg.sv
// Shared cartridge helpers: header-byte decode, save-sector sizing and the
// backup sequencer state encoding.
package gb_cart_pkg;

  localparam int unsigned SECTOR_BYTES = 512;
  localparam int unsigned CRAM_AW      = 17;

  typedef enum logic [2:0] {IDLE, REQ, XFER, NEXT, DONE} bk_state_t;

  function automatic logic is_mbc2(input logic [7:0] mbc_type);
    return (mbc_type == 8'h05) || (mbc_type == 8'h06);
  endfunction

  function automatic logic has_battery(input logic [7:0] mbc_type);
    case (mbc_type)
      8'h03, 8'h06, 8'h09, 8'h0D, 8'h0F, 8'h10,
      8'h13, 8'h1B, 8'h1E, 8'h22, 8'hFF: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  // MBC2 carries 512 nibbles of internal RAM regardless of the size code.
  function automatic logic [7:0] last_sector(input logic [7:0] mbc_type,
                                             input logic [7:0] ram_size);
    if (is_mbc2(mbc_type)) return 8'd0;
    case (ram_size)
      8'd0:    return 8'd0;
      8'd1:    return 8'd3;
      8'd2:    return 8'd15;
      8'd3:    return 8'd63;
      default: return 8'd255;
    endcase
  endfunction

endpackage

// File: rtl/cram_backup_if.sv
// Host block-transfer handshake between the backup sequencer (master) and
// the SD image host (slave).
interface cram_backup_if #(
  parameter int unsigned LBA_W = 8
);
  logic [LBA_W-1:0] sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             sd_ack;
  logic [8:0]       sd_buff_addr;
  logic [7:0]       sd_buff_dout;
  logic             sd_buff_wr;
  logic [7:0]       sd_buff_din;

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr
  );
endinterface

// File: rtl/cram_backup_timeout.sv
// Loadable down-counter; expired is raised while enabled once the count has
// run out.
module cram_backup_timeout #(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/cram_backup.sv
// Cart RAM save/load sequencer on RAM port B, one SD sector per request.
// Optional macro CRAM_DIRTY_EN: track CPU writes and skip saves of clean RAM.
module cram_backup
  import gb_cart_pkg::*;
#(
  parameter int unsigned LBA_W   = 8,
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [7:0]  cart_mbc_type,
  input  logic [7:0]  cart_ram_size,
  input  logic        img_mounted,
  input  logic [31:0] img_size,
  input  logic        bk_load,
  input  logic        bk_save,
  input  logic        cram_wr_cpu,
  cram_backup_if.master sd,
  output logic [16:0] cram_addr,
  output logic        cram_we,
  output logic [7:0]  cram_wdata,
  input  logic [7:0]  cram_rdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        dirty
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT - 1);

  bk_state_t        state;
  bk_state_t        state_n;
  logic [LBA_W-1:0] lba;
  logic [LBA_W-1:0] last_lba;
  logic             save_dir;
  logic             error_q;
  logic             mounted;
  logic             save_ok;
  logic             supported;
  logic             accept_load;
  logic             accept_save;
  logic             tmr_load;
  logic             tmr_expired;

  assign supported   = has_battery(cart_mbc_type) &&
                       ((cart_ram_size != 8'd0) || is_mbc2(cart_mbc_type));
  assign accept_load = mounted && supported && bk_load;
  assign accept_save = mounted && supported && !bk_load && bk_save && save_ok;

  cram_backup_timeout #(
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (TO_LOAD),
    .en       (state == REQ),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    tmr_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept_load || accept_save) begin
          state_n  = REQ;
          tmr_load = 1'b1;
        end
      end
      REQ: begin
        // An ack arriving on the last counted cycle still wins over timeout.
        if (sd.sd_ack)        state_n = XFER;
        else if (tmr_expired) state_n = IDLE;
      end
      XFER: begin
        if (!sd.sd_ack) state_n = NEXT;
      end
      NEXT: begin
        if (lba == last_lba) begin
          state_n = DONE;
        end else begin
          state_n  = REQ;
          tmr_load = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lba      <= '0;
      last_lba <= '0;
      save_dir <= 1'b0;
      error_q  <= 1'b0;
      mounted  <= 1'b0;
    end else begin
      if (img_mounted) mounted <= (img_size != '0);
      case (state)
        IDLE: begin
          if (accept_load || accept_save) begin
            save_dir <= !accept_load;
            lba      <= '0;
            last_lba <= LBA_W'(last_sector(cart_mbc_type, cart_ram_size));
            error_q  <= 1'b0;
          end
        end
        REQ: begin
          if (!sd.sd_ack && tmr_expired) error_q <= 1'b1;
        end
        NEXT: begin
          if (lba != last_lba) lba <= lba + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CRAM_DIRTY_EN
  logic dirty_q;

  // A CPU write landing in the DONE cycle keeps the RAM marked dirty.
  always_ff @(posedge clk_sys) begin
    if (reset)              dirty_q <= 1'b0;
    else if (cram_wr_cpu)   dirty_q <= 1'b1;
    else if (state == DONE) dirty_q <= 1'b0;
  end

  assign save_ok = dirty_q;
  assign dirty   = dirty_q;
`else
  logic unused_cram_wr_cpu;

  assign unused_cram_wr_cpu = cram_wr_cpu;
  assign save_ok            = 1'b1;
  assign dirty              = 1'b0;
`endif

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign error = error_q;

  assign sd.sd_lba      = lba;
  assign sd.sd_rd       = (state == REQ) && !save_dir;
  assign sd.sd_wr       = (state == REQ) &&  save_dir;
  assign sd.sd_buff_din = busy ? cram_rdata : '0;

  assign cram_addr  = busy ? 17'({lba, sd.sd_buff_addr}) : '0;
  assign cram_we    = (state == XFER) && !save_dir && sd.sd_buff_wr && sd.sd_ack;
  assign cram_wdata = ((state == XFER) && !save_dir) ? sd.sd_buff_dout : '0;

endmodule

// File: doc/cram_backup.md
Name: cram_backup

Overview:
- Save/load sequencer on the otherwise idle second port of the cartridge RAM (port B, clk_sys side).
- Moves battery-backed cart RAM to/from the SD image one 512-byte sector at a time, using the host block-transfer handshake (sd_lba / sd_rd / sd_wr / sd_ack plus byte buffer strobes).
- Sits beside the cart mapper; the CPU side of the cart RAM is untouched.

Parameters:
- LBA_W, 8: width of the sector counter and sd_lba; 256 sectors = 128 KB maximum.
- TIMEOUT, 1048576: clk_sys cycles to wait for sd_ack rise before aborting a request.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- cart_mbc_type  in  8  cartridge header type byte.
- cart_ram_size  in  8  cartridge header RAM size code.
- img_mounted  in  1  one-cycle pulse when a save image is (re)mounted.
- img_size  in  32  image size in bytes, valid with img_mounted.
- bk_load  in  1  load request, level-sampled in IDLE.
- bk_save  in  1  save request, level-sampled in IDLE.
- cram_wr_cpu  in  1  CPU-side cart RAM write strobe (dirty tracking).
- sd_lba  out  LBA_W  sector number for the current request.
- sd_rd  out  1  sector read request (image to RAM).
- sd_wr  out  1  sector write request (RAM to image).
- sd_ack  in  1  host owns the buffer while high.
- sd_buff_addr  in  9  byte index within the sector.
- sd_buff_dout  in  8  host data for loads.
- sd_buff_wr  in  1  host byte strobe for loads.
- sd_buff_din  out  8  RAM data for saves.
- cram_addr  out  17  cart RAM port B address.
- cram_we  out  1  cart RAM port B write enable.
- cram_wdata  out  8  cart RAM port B write data.
- cram_rdata  in  8  cart RAM port B read data, 1-cycle latency.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky timeout flag; cleared by the next accepted request.
- dirty  out  1  cart RAM modified since last load/save.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; lba 0; mounted 0.
- mounted: set by img_mounted with img_size != 0; cleared by img_mounted with img_size == 0.
- supported = battery type && (cart_ram_size != 0 || mbc2).
- Last sector:
  - mbc2: 0.
  - ram_size 1: 3.
  - ram_size 2: 15.
  - ram_size 3: 63.
  - ram_size >= 4: 255.
- Request acceptance:
  - IDLE accepts a request only if mounted && supported; otherwise the request is ignored with no done pulse.
  - bk_load and bk_save together: load wins.
  - Requests while busy are ignored.
- FSM IDLE -> REQ:
  - Captures direction, lba = 0, clears error.
- REQ:
  - Assert sd_rd (load) or sd_wr (save).
  - Hold until sd_ack = 1, then drop the request and go to XFER.
  - Timeout counter reaching TIMEOUT-1: go to IDLE, set error, no done.
- XFER (while sd_ack = 1):
  - cram_addr = {lba, sd_buff_addr}, zero-extended to 17 bits.
  - Load: cram_we = sd_buff_wr & sd_ack, cram_wdata = sd_buff_dout, combinational, same cycle.
  - Save: sd_buff_din = cram_rdata; valid one cycle after sd_buff_addr changes.
  - sd_ack falling edge -> NEXT.
- NEXT:
  - If lba == last: go to DONE.
  - Else: lba += 1, go to REQ.
  - lba never wraps past last.
- DONE: pulse done one cycle, clear dirty, go to IDLE.
- Total latency: request sampled -> sd_rd/sd_wr asserted on the next cycle.
- reset mid-transfer: next cycle IDLE, sd_rd/sd_wr = 0, cram_we = 0, no done pulse.

Optional Feature:
- Macro CRAM_DIRTY_EN.
- Defined:
  - dirty set by cram_wr_cpu.
  - bk_save accepted only when dirty = 1; otherwise ignored.
  - dirty clears at DONE.
  - cram_wr_cpu in the same cycle as DONE wins, leaving dirty = 1.
- Undefined: dirty tied 0; saves always proceed.

Decomposition:
- Shared package gb_cart_pkg:
  - MBC type decode functions (is_mbc2, has_battery).
  - RAM-size-code to last-sector function.
  - FSM state enum {IDLE, REQ, XFER, NEXT, DONE}.
  - SECTOR_BYTES = 512.
- One natural sub-module: cram_backup_timeout (loadable down-counter with expired flag).

Test Plan:
- Type 0x03, ram_size 2, mount 8192, bk_load: 16 sectors, lba 0..15, each sd_ack then 512 sd_buff_wr -> cram writes at {lba,addr}, done pulses once, busy falls.
- Type 0x06 (mbc2), bk_save: single sector lba 0 -> sd_buff_din equals preloaded RAM bytes 0..511 one cycle after each address; done.
- Type 0x01 (no battery), bk_save -> sd_wr never asserts, busy stays 0, no done.
- No sd_ack after sd_rd with TIMEOUT = 64 -> error = 1 at cycle 64, busy = 0; next bk_load clears error.
- reset asserted mid-XFER of sector 5 -> next cycle sd_rd = sd_wr = cram_we = 0, FSM IDLE, lba = 0.
- CRAM_DIRTY_EN: bk_save with dirty = 0 ignored; one cram_wr_cpu then bk_save -> save runs, dirty = 0 after done.
